// File: rtl/pipeline_0_fetch.sv
// pipeline_0_fetch: front-end fetch stage. Owns the PC, fetches 16-bit
// instructions over a valid-qualified memory port into the instruction
// register, and issues decoded fields (or NOP bubbles) to the read-register
// stage.
// Ports:
//   clk, rst                 clock, async active-low reset
//   imem_req/addr/rdata/valid instruction memory port (addr = pc)
//   ir                       instruction register, to external decoder
//   dec_*                    decoder results for ir
//   rr_loads, rr_num_Rd      load in read-register stage and its destination
//   branch_taken/target      redirect from execute
//   hold                     downstream freeze
//   control_out, num_*_out, imm_out, update   read-register stage inputs
//   bubble_count             saturating count of issued bubbles
module pipeline_0_fetch #(
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter logic [21:0] NOP_CONTROL = 22'h000000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_rdata,
  input  logic        imem_valid,
  output logic [15:0] ir,
  input  logic [21:0] dec_control,
  input  logic [15:0] dec_imm,
  input  logic        dec_uses_Rm,
  input  logic        dec_uses_Rn,
  input  logic        rr_loads,
  input  logic [2:0]  rr_num_Rd,
  input  logic        branch_taken,
  input  logic [15:0] branch_target,
  input  logic        hold,
  output logic [21:0] control_out,
  output logic [2:0]  num_Rm_out,
  output logic [2:0]  num_Rn_out,
  output logic [2:0]  num_Rd_out,
  output logic [15:0] imm_out,
  output logic        update,
  output logic [15:0] bubble_count
);

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned CNT_W  = 16;

  typedef enum logic {FETCH, ISSUE} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [15:0]         ir_q, ir_d;
  logic [CNT_W-1:0]    bcnt_q, bcnt_d;

  logic [2:0] rn, rd, rm;
  logic       hazard;
  logic       issue;

  assign rn = ir_q[10:8];
  assign rd = ir_q[7:5];
  assign rm = ir_q[2:0];

  // Load-use hazard: IR reads the register the load in read-register writes.
  assign hazard = (state_q == ISSUE) & rr_loads &
                  ((dec_uses_Rm & (rm == rr_num_Rd)) |
                   (dec_uses_Rn & (rn == rr_num_Rd)));
  assign issue  = (state_q == ISSUE) & ~hazard & ~hold & ~branch_taken;

  assign ir           = ir_q;
  assign imem_addr    = pc_q;
  assign bubble_count = bcnt_q;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= 16'h0000;
      bcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      bcnt_q  <= bcnt_d;
    end
  end

  // Next-state and downstream outputs.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    bcnt_d      = bcnt_q;
    control_out = NOP_CONTROL;
    num_Rm_out  = 3'd0;
    num_Rn_out  = 3'd0;
    num_Rd_out  = 3'd0;
    imm_out     = 16'h0000;
    // Reset forces the enable and the request high regardless of hold/branch.
    update      = ~rst | ~hold;
    imem_req    = ~rst | (~branch_taken & ((state_q == FETCH) | issue));

    if (issue) begin
      control_out = dec_control;
      num_Rm_out  = rm;
      num_Rn_out  = rn;
      num_Rd_out  = rd;
      imm_out     = dec_imm;
    end

    if (update && !issue && (bcnt_q != {CNT_W{1'b1}})) begin
      bcnt_d = bcnt_q + CNT_W'(1);
    end

    if (branch_taken) begin
      // Redirect wins over everything; memory data this cycle is dropped.
      pc_d    = branch_target;
      state_d = FETCH;
    end else begin
      unique case (state_q)
        FETCH: begin
          // Capture is allowed even under hold.
          if (imem_valid) begin
            ir_d    = imem_rdata;
            pc_d    = pc_q + ADDR_W'(1);
            state_d = ISSUE;
          end
        end
        ISSUE: begin
          if (issue) begin
            if (imem_valid) begin
              ir_d = imem_rdata;
              pc_d = pc_q + ADDR_W'(1);
            end else begin
              state_d = FETCH;
            end
          end
        end
        default: state_d = FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_0_fetch.sv
// Testbench for pipeline_0_fetch: directed scenarios plus a randomized run.
// A scoreboard queue holds the next instruction expected in program order;
// a monitor pops it whenever the DUT issues, and checks bubble rules.
module tb_pipeline_0_fetch;

  localparam logic [15:0] RST_PC = 16'h0000;
  localparam logic [21:0] NOP    = 22'h000000;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata;
  logic        imem_valid;
  logic [15:0] ir;
  logic [21:0] dec_control;
  logic [15:0] dec_imm;
  logic        dec_uses_Rm;
  logic        dec_uses_Rn;
  logic        rr_loads;
  logic [2:0]  rr_num_Rd;
  logic        branch_taken;
  logic [15:0] branch_target;
  logic        hold;
  logic [21:0] control_out;
  logic [2:0]  num_Rm_out;
  logic [2:0]  num_Rn_out;
  logic [2:0]  num_Rd_out;
  logic [15:0] imm_out;
  logic        update;
  logic [15:0] bubble_count;

  logic        stall;
  logic [1:0]  rm_sel;
  logic [1:0]  rn_sel;

  int n_checks = 0;
  int n_pass   = 0;
  int n_issued = 0;

  logic [15:0] q[$];
  logic [15:0] sb_next;
  int unsigned exp_bc = 0;

  pipeline_0_fetch #(.RESET_PC(RST_PC), .NOP_CONTROL(NOP)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .imem_valid(imem_valid), .ir(ir),
    .dec_control(dec_control), .dec_imm(dec_imm),
    .dec_uses_Rm(dec_uses_Rm), .dec_uses_Rn(dec_uses_Rn),
    .rr_loads(rr_loads), .rr_num_Rd(rr_num_Rd),
    .branch_taken(branch_taken), .branch_target(branch_target), .hold(hold),
    .control_out(control_out), .num_Rm_out(num_Rm_out),
    .num_Rn_out(num_Rn_out), .num_Rd_out(num_Rd_out),
    .imm_out(imm_out), .update(update), .bubble_count(bubble_count)
  );

  // Program memory contents and decoder model.
  function automatic logic [15:0] mem_data(input logic [15:0] a);
    return 16'h1000 + a;
  endfunction

  assign imem_rdata  = mem_data(imem_addr);
  assign imem_valid  = imem_req & ~stall;
  assign dec_control = {6'h3F, ir};
  assign dec_imm     = ir ^ 16'hA5A5;
  assign dec_uses_Rm = (rm_sel == 2'd0) ? ir[3] : (rm_sel == 2'd1);
  assign dec_uses_Rn = (rn_sel == 2'd0) ? ir[4] : (rn_sel == 2'd1);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Program flow restarts at address a: the next issued instruction is mem[a].
  task automatic sb_redirect(input logic [15:0] a);
    q.delete();
    q.push_back(mem_data(a));
    sb_next = a + 16'd1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  // Monitor: every issue must be the next instruction in program order;
  // bubbles must be clean and counted whenever update is high.
  always @(negedge clk) begin
    logic        haz;
    logic [15:0] d;
    if (!rst) begin
      exp_bc = 0;
    end else begin
      haz = rr_loads && ((dec_uses_Rm && (ir[2:0] == rr_num_Rd)) ||
                         (dec_uses_Rn && (ir[10:8] == rr_num_Rd)));
      chk("bubble_count", 32'(bubble_count), 32'(exp_bc));
      chk("update", 32'(update), 32'(!hold));
      if (branch_taken) chk("branch_req", 32'(imem_req), 32'd0);
      if (control_out != NOP) begin
        chk("issue_allowed", 32'(hold || branch_taken || haz), 32'd0);
        if (q.size() == 0) begin
          chk("sb_empty", 32'd1, 32'd0);
        end else begin
          d = q.pop_front();
          q.push_back(mem_data(sb_next));
          sb_next = sb_next + 16'd1;
          chk("issue_fields",
              32'({control_out, num_Rn_out, num_Rd_out, num_Rm_out}),
              32'({6'h3F, d, d[10:8], d[7:5], d[2:0]}));
          chk("issue_imm", 32'(imm_out), 32'(d ^ 16'hA5A5));
        end
        n_issued++;
      end else begin
        chk("bubble_payload", 32'({num_Rn_out, num_Rd_out, num_Rm_out, imm_out}), 32'd0);
        if (!hold && exp_bc < 32'hFFFF) exp_bc = exp_bc + 1;
      end
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] ir0, pc0, bc0;
    int          iss0;

    rst = 1'b0; hold = 1'b0; stall = 1'b0; rr_loads = 1'b0; rr_num_Rd = 3'd0;
    branch_taken = 1'b0; branch_target = 16'h0000; rm_sel = 2'd0; rn_sel = 2'd0;
    sb_redirect(RST_PC);
    tick();
    hold = 1'b1;
    at_neg();
    chk("rst_req", 32'(imem_req), 32'd1);
    chk("rst_addr", 32'(imem_addr), 32'(RST_PC));
    chk("rst_update", 32'(update), 32'd1);
    chk("rst_ctrl", 32'(control_out), 32'(NOP));
    chk("rst_ir", 32'(ir), 32'd0);
    chk("rst_bc", 32'(bubble_count), 32'd0);
    tick();
    hold = 1'b0;
    rst  = 1'b1;

    // Zero-wait stream: one FETCH bubble, then one instruction per cycle.
    at_neg();
    chk("c0_addr", 32'(imem_addr), 32'd0);
    chk("c0_bubble", 32'(control_out), 32'(NOP));
    for (int k = 0; k < 4; k++) begin
      tick();
      at_neg();
      chk("stream_ir", 32'(ir), 32'(mem_data(16'(k))));
      chk("stream_addr", 32'(imem_addr), 32'(k + 1));
    end
    chk("stream_bc", 32'(bubble_count), 32'd1);

    // Load-use on Rm: exactly one bubble, same instruction issues next.
    tick();
    rr_loads = 1'b1; rr_num_Rd = ir[2:0]; rm_sel = 2'd1; rn_sel = 2'd2;
    at_neg();
    chk("lu_bubble", 32'(control_out), 32'(NOP));
    chk("lu_req", 32'(imem_req), 32'd0);
    ir0 = ir; pc0 = imem_addr; bc0 = bubble_count;
    tick();
    rr_loads = 1'b0;
    at_neg();
    chk("lu_ir_held", 32'(ir), 32'(ir0));
    chk("lu_pc_held", 32'(imem_addr), 32'(pc0));
    chk("lu_reissue", 32'(control_out), 32'({6'h3F, ir0}));
    chk("lu_bc", 32'(bubble_count), 32'(bc0 + 16'd1));

    // Non-matching register, then matching register without Rm use.
    tick();
    rr_loads = 1'b1; rr_num_Rd = ir[2:0] ^ 3'd4; rm_sel = 2'd1; rn_sel = 2'd2;
    at_neg();
    chk("nomatch_issue", 32'(control_out), 32'({6'h3F, ir}));
    tick();
    rr_num_Rd = ir[2:0]; rm_sel = 2'd2;
    at_neg();
    chk("nouse_issue", 32'(control_out), 32'({6'h3F, ir}));
    tick();
    rr_loads = 1'b0; rm_sel = 2'd0; rn_sel = 2'd0;

    // Hold for three cycles in ISSUE: everything frozen, no request.
    hold = 1'b1;
    ir0 = ir; pc0 = imem_addr; bc0 = bubble_count;
    for (int k = 0; k < 3; k++) begin
      at_neg();
      chk("hold_update", 32'(update), 32'd0);
      chk("hold_req", 32'(imem_req), 32'd0);
      chk("hold_ir", 32'(ir), 32'(ir0));
      chk("hold_pc", 32'(imem_addr), 32'(pc0));
      chk("hold_bc", 32'(bubble_count), 32'(bc0));
      tick();
    end
    hold = 1'b0;
    at_neg();
    chk("hold_resume", 32'(control_out), 32'({6'h3F, ir0}));

    // Branch to 0040 while memory returns valid data.
    tick();
    branch_taken = 1'b1; branch_target = 16'h0040;
    sb_redirect(16'h0040);
    at_neg();
    chk("br_bubble", 32'(control_out), 32'(NOP));
    tick();
    branch_taken = 1'b0;
    at_neg();
    chk("br_addr", 32'(imem_addr), 32'h0040);
    chk("br_fetch_bubble", 32'(control_out), 32'(NOP));
    tick();
    at_neg();
    chk("br_first_ir", 32'(ir), 32'(mem_data(16'h0040)));
    chk("br_first_issue", 32'(control_out), 32'({6'h3F, mem_data(16'h0040)}));

    // PC wrap at FFFF.
    tick();
    branch_taken = 1'b1; branch_target = 16'hFFFF;
    sb_redirect(16'hFFFF);
    tick();
    branch_taken = 1'b0;
    at_neg();
    chk("wrap_addr_ffff", 32'(imem_addr), 32'hFFFF);
    tick();
    at_neg();
    chk("wrap_ir", 32'(ir), 32'(mem_data(16'hFFFF)));
    chk("wrap_addr_0", 32'(imem_addr), 32'h0000);
    tick();
    at_neg();
    chk("wrap_ir_next", 32'(ir), 32'(mem_data(16'h0000)));

    // Randomized traffic: wait states, holds, load hazards, branches.
    iss0 = n_issued;
    for (int i = 0; i < 2000; i++) begin
      tick();
      hold      = ($urandom_range(0, 9) == 0);
      stall     = ($urandom_range(0, 3) == 0);
      rr_loads  = ($urandom_range(0, 2) == 0);
      rr_num_Rd = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 19) == 0) begin
        branch_taken  = 1'b1;
        branch_target = 16'($urandom);
        sb_redirect(branch_target);
      end else begin
        branch_taken = 1'b0;
      end
    end
    tick();
    hold = 1'b0; stall = 1'b0; rr_loads = 1'b0; branch_taken = 1'b0;
    at_neg();
    chk("random_progress", 32'(n_issued - iss0 > 400), 32'd1);

    // Saturate the bubble counter with a long run of redirects.
    tick();
    branch_taken = 1'b1; branch_target = 16'h0000;
    sb_redirect(16'h0000);
    repeat (65540) tick();
    branch_taken = 1'b0;
    at_neg();
    chk("sat_bc", 32'(bubble_count), 32'hFFFF);
    repeat (4) tick();
    at_neg();
    chk("sat_bc_hold", 32'(bubble_count), 32'hFFFF);

    // Asynchronous reset mid-run takes effect immediately.
    tick();
    hold = 1'b1;
    rst  = 1'b0;
    sb_redirect(RST_PC);
    #1;
    chk("arst_addr", 32'(imem_addr), 32'(RST_PC));
    chk("arst_ir", 32'(ir), 32'd0);
    chk("arst_bc", 32'(bubble_count), 32'd0);
    chk("arst_req", 32'(imem_req), 32'd1);
    chk("arst_update", 32'(update), 32'd1);
    chk("arst_ctrl", 32'(control_out), 32'(NOP));
    tick();
    hold = 1'b0;
    rst  = 1'b1;
    tick();
    at_neg();
    chk("rerun_ir", 32'(ir), 32'(mem_data(RST_PC)));
    repeat (3) tick();
    at_neg();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
